// File: rtl/stim_seq.sv
// Purpose: stimulus bit sequencer emitting LEN bits per run from a counter or Galois LFSR pattern register.
// Latency: first bit appears on a one cycle after start is sampled; done pulses one cycle after the last consumed bit.
// Backpressure: hold stalls the current bit (RUN->PAUSE), pattern and count frozen until hold drops.
module stim_seq #(
    parameter int          MODE = 0,      // 0 = binary up-counter, 1 = 8-bit Galois LFSR
    parameter int          LEN  = 8,      // bits emitted per run, 1..255
    parameter logic [7:0]  SEED = 8'hA5   // value loaded into the pattern register at run start
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       hold,
    output logic       a,
    output logic       a_valid,
    output logic       busy,
    output logic       done,
    output logic [7:0] count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // An all-zero LFSR never leaves zero, so substitute a non-zero load value.
    localparam logic [7:0] LOAD_VAL = ((MODE == 1) && (SEED == 8'h00)) ? 8'h01 : SEED;
    localparam logic [7:0] LEN_B    = 8'(LEN);
    localparam logic [7:0] LFSR_TAP = 8'hB8;

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_pattern;
    logic [7:0] r_count;
    logic [7:0] w_pattern_adv;
    logic [7:0] w_count_inc;
    logic       w_load;
    logic       w_consume;
    logic       w_last;

    // Next pattern value for either sequence source.
    always_comb begin
        w_pattern_adv = r_pattern + 8'd1;
        if (MODE == 1) begin
            w_pattern_adv = (r_pattern >> 1) ^ (r_pattern[0] ? LFSR_TAP : 8'h00);
        end
    end

    // count never exceeds LEN-1 while in RUN, so the 8-bit increment cannot wrap here.
    assign w_count_inc = r_count + 8'd1;
    assign w_last      = (w_count_inc == LEN_B);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus load/consume strobes for the datapath.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_consume    = 1'b0;
        case (r_state)
            IDLE: begin
                // hold is irrelevant on the launching edge
                if (start) begin
                    w_next_state = RUN;
                    w_load       = 1'b1;
                end
            end
            RUN: begin
                if (hold) begin
                    w_next_state = PAUSE;
                end else begin
                    w_consume = 1'b1;
                    if (w_last) begin
                        w_next_state = DONE;
                    end
                end
            end
            PAUSE: begin
                // resuming edge only re-enters RUN; the pending bit is consumed later
                if (!hold) begin
                    w_next_state = RUN;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Pattern and bit counter: load at run start, advance on every consumed bit, otherwise hold.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pattern <= 8'h00;
            r_count   <= 8'h00;
        end else if (w_load) begin
            r_pattern <= LOAD_VAL;
            r_count   <= 8'h00;
        end else if (w_consume) begin
            r_pattern <= w_pattern_adv;
            r_count   <= w_count_inc;
        end
    end

    // All outputs are decoded purely from registered state.
    assign a       = r_pattern[0];
    assign a_valid = (r_state == RUN);
    assign busy    = (r_state != IDLE);
    assign done    = (r_state == DONE);
    assign count   = r_count;

endmodule

// File: tb/tb_stim_seq.sv
// Bench for stim_seq: four parameterisations driven one at a time, expected bits/done counts queued by stimulus.
// A negedge monitor pops and compares on every consumed bit and every done pulse.
// Direct checks cover reset values, pause behaviour and asynchronous mid-run reset.
module tb_stim_seq;

    typedef struct {
        int         inst;
        bit         is_done;
        logic [7:0] val;
    } evt_t;

    logic       clock;
    logic       reset_n;
    logic [3:0] start_v;
    logic [3:0] hold_v;
    logic [3:0] a_v;
    logic [3:0] av_v;
    logic [3:0] busy_v;
    logic [3:0] done_v;
    logic [7:0] cnt_v [4];

    evt_t exp_q[$];
    int   checks;
    int   errors;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // u0: counter, SEED 0, LEN 4
    stim_seq #(.MODE(0), .LEN(4), .SEED(8'h00)) u0 (
        .clock(clock), .reset_n(reset_n), .start(start_v[0]), .hold(hold_v[0]),
        .a(a_v[0]), .a_valid(av_v[0]), .busy(busy_v[0]), .done(done_v[0]), .count(cnt_v[0]));
    // u1: LFSR, SEED A5, LEN 5
    stim_seq #(.MODE(1), .LEN(5), .SEED(8'hA5)) u1 (
        .clock(clock), .reset_n(reset_n), .start(start_v[1]), .hold(hold_v[1]),
        .a(a_v[1]), .a_valid(av_v[1]), .busy(busy_v[1]), .done(done_v[1]), .count(cnt_v[1]));
    // u2: counter, SEED A5, LEN 8
    stim_seq #(.MODE(0), .LEN(8), .SEED(8'hA5)) u2 (
        .clock(clock), .reset_n(reset_n), .start(start_v[2]), .hold(hold_v[2]),
        .a(a_v[2]), .a_valid(av_v[2]), .busy(busy_v[2]), .done(done_v[2]), .count(cnt_v[2]));
    // u3: LFSR, SEED 0 (lockup guard), LEN 3
    stim_seq #(.MODE(1), .LEN(3), .SEED(8'h00)) u3 (
        .clock(clock), .reset_n(reset_n), .start(start_v[3]), .hold(hold_v[3]),
        .a(a_v[3]), .a_valid(av_v[3]), .busy(busy_v[3]), .done(done_v[3]), .count(cnt_v[3]));

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int i, input bit d, input logic [7:0] v);
        evt_t e;
        e.inst    = i;
        e.is_done = d;
        e.val     = v;
        exp_q.push_back(e);
    endtask

    // Queue n bits taken LSB-first from pat, optionally followed by a done event carrying count n.
    task automatic push_bits(input int i, input logic [7:0] pat, input int n, input bit with_done);
        for (int k = 0; k < n; k++) push(i, 1'b0, {7'b0, pat[k]});
        if (with_done) push(i, 1'b1, 8'(n));
    endtask

    task automatic check_evt(input int i, input bit d, input logic [7:0] v);
        evt_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s u%0d: got %0h, expected no event", d ? "done" : "bit", i, v);
        end else begin
            e = exp_q.pop_front();
            if (e.inst != i || e.is_done != d || e.val !== v) begin
                errors++;
                $display("FAIL event: got u%0d %s=%0h, expected u%0d %s=%0h",
                         i, d ? "done_count" : "bit", v, e.inst, e.is_done ? "done_count" : "bit", e.val);
            end
        end
    endtask

    // Monitor: a bit is consumed when a_valid is high and hold low at the upcoming edge.
    always @(negedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (av_v[i] && !hold_v[i]) check_evt(i, 1'b0, {7'b0, a_v[i]});
            if (done_v[i]) check_evt(i, 1'b1, cnt_v[i]);
        end
    end

    task automatic run_start(input int i);
        @(posedge clock); #1 start_v[i] = 1'b1;
        @(posedge clock); #1 start_v[i] = 1'b0;
    endtask

    // Returns at the negedge where done is seen, or flags a timeout.
    task automatic wait_done(input int i);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clock);
            if (done_v[i]) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout u%0d: got no done, expected done within 60 cycles", i);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        start_v = 4'b0;
        hold_v  = 4'b0;

        // Reset state of every instance
        #12;
        for (int i = 0; i < 4; i++) begin
            chk("rst_a",       {7'b0, a_v[i]},    8'h00);
            chk("rst_a_valid", {7'b0, av_v[i]},   8'h00);
            chk("rst_busy",    {7'b0, busy_v[i]}, 8'h00);
            chk("rst_done",    {7'b0, done_v[i]}, 8'h00);
            chk("rst_count",   cnt_v[i],          8'h00);
        end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        chk("no_bits_before_start", {7'b0, busy_v[0]}, 8'h00);

        // Counter from 0, LEN 4: a = 0,1,0,1 then done with count 4
        push_bits(0, 8'h0A, 4, 1'b1);
        run_start(0);
        wait_done(0);
        @(negedge clock);
        chk("idle_busy_u0",  {7'b0, busy_v[0]}, 8'h00);
        chk("idle_count_u0", cnt_v[0], 8'h04);

        // LFSR A5, LEN 5: a = 1,0,1,0,1; start re-pulsed mid-run must not reload
        push_bits(1, 8'h15, 5, 1'b1);
        run_start(1);
        @(posedge clock); #1 start_v[1] = 1'b1;
        @(posedge clock); #1 start_v[1] = 1'b0;
        wait_done(1);
        @(negedge clock);
        chk("idle_count_u1", cnt_v[1], 8'h05);

        // Counter A5, LEN 8 with a 3-cycle stall after the 2nd bit
        push_bits(2, 8'h55, 8, 1'b1);
        run_start(2);
        @(posedge clock);
        @(posedge clock); #1 hold_v[2] = 1'b1;
        @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin
                @(posedge clock); #1 hold_v[2] = 1'b0;
            end
            @(negedge clock);
            chk("pause_a_valid", {7'b0, av_v[2]}, 8'h00);
            chk("pause_a",       {7'b0, a_v[2]},  8'h01);
            chk("pause_count",   cnt_v[2],        8'h02);
        end
        wait_done(2);

        // Asynchronous reset while the 3rd bit of u0 is presented
        push_bits(0, 8'h0A, 2, 1'b0);
        run_start(0);
        @(posedge clock);
        @(posedge clock); #2 reset_n = 1'b0;
        #1;
        chk("async_a",       {7'b0, a_v[0]},    8'h00);
        chk("async_a_valid", {7'b0, av_v[0]},   8'h00);
        chk("async_busy",    {7'b0, busy_v[0]}, 8'h00);
        chk("async_done",    {7'b0, done_v[0]}, 8'h00);
        chk("async_count",   cnt_v[0],          8'h00);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (6) @(negedge clock);
        chk("post_reset_idle", {7'b0, busy_v[0]}, 8'h00);
        push_bits(0, 8'h0A, 4, 1'b1);
        run_start(0);
        wait_done(0);

        // LFSR with zero seed: loads 01, a = 1,0,0
        push_bits(3, 8'h01, 3, 1'b1);
        run_start(3);
        wait_done(3);

        repeat (5) @(negedge clock);
        chk("queue_empty", 8'(exp_q.size()), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stim_seq.md
STIM_SEQ -- requirements
Module: stim_seq

Interface
REQ-001 SHALL have parameter MODE, default 0, meaning sequence source select: 0 = binary up-counter, 1 = 8-bit Galois LFSR.
REQ-002 SHALL have parameter LEN, default 8, meaning bits emitted per run; legal range 1..255.
REQ-003 SHALL have parameter SEED, default 8'hA5, meaning 8-bit value loaded into the pattern register at run start.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clock  input  1  rising-edge system clock.
REQ-006 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port start  input  1  run request, sampled on posedge clock.
REQ-008 SHALL have port hold  input  1  downstream stall; the current bit is not consumed while high.
REQ-009 SHALL have port a  output  1  stimulus bit, equal to pattern[0]; drives the data input of the downstream sampling stage.
REQ-010 SHALL have port a_valid  output  1  a carries a live bit; high only in state RUN.
REQ-011 SHALL have port busy  output  1  high in RUN, PAUSE and DONE.
REQ-012 SHALL have port done  output  1  one-cycle pulse marking run completion.
REQ-013 SHALL have port count  output  8  number of bits consumed in the current or last run.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, PAUSE and DONE, all registered.
REQ-015 SHALL move IDLE->RUN on an edge with start=1, load pattern<=SEED and clear count<=0; hold is ignored on that edge.
REQ-016 SHALL, in LFSR mode with SEED=0, load 8'h01 in place of SEED to avoid lockup.
REQ-017 SHALL define a bit as consumed on an edge where state=RUN and hold=0.
REQ-018 SHALL, on each consumed edge, advance pattern and increment count.
REQ-019 SHALL advance pattern in counter mode as pattern+1, wrapping 8'hFF->8'h00.
REQ-020 SHALL advance pattern in LFSR mode as (pattern>>1) XOR (pattern[0] ? 8'hB8 : 8'h00).
REQ-021 SHALL move RUN->DONE on the consumed edge where count+1 = LEN, so exactly LEN bits are consumed.
REQ-022 SHALL move RUN->PAUSE on an edge with hold=1, leaving pattern and count unchanged.
REQ-023 SHALL move PAUSE->RUN on an edge with hold=0; a SHALL hold its value throughout PAUSE.
REQ-024 SHALL assert done for exactly the one cycle spent in DONE, then move DONE->IDLE unconditionally.
REQ-025 SHALL ignore start in RUN, PAUSE and DONE; no restart and no reload.
REQ-026 SHALL keep count at its final value in IDLE until the next start.
REQ-027 SHALL keep a_valid low in IDLE, PAUSE and DONE.
REQ-028 SHALL decode all outputs from registers with no combinational path from an input to an output.

Reset
REQ-029 SHALL, while reset_n=0, force state=IDLE, pattern=0, count=0, a=0, a_valid=0, busy=0 and done=0, independent of clock.
REQ-030 SHALL, on reset asserted mid-run (RUN or PAUSE), abandon the run immediately with no done pulse.
REQ-031 SHALL require start after reset release before any bit is emitted.

Verification
REQ-032 SHALL cover: MODE=0, SEED=0, LEN=4, start pulse, hold=0 -> a_valid high 4 cycles with a = 0,1,0,1; done pulses on the next cycle; count=4.
REQ-033 SHALL cover: MODE=1, SEED=8'hA5, LEN=5 -> pattern A5,EA,75,82,41 and a = 1,0,1,0,1; then done; count=5.
REQ-034 SHALL cover: MODE=0, LEN=8, hold=1 for 3 cycles after the 2nd bit -> a_valid low 3 cycles, a steady, count stays 2; resume gives 8 bits total.
REQ-035 SHALL cover: start re-pulsed mid-run -> no reload; the original run completes with LEN bits.
REQ-036 SHALL cover: reset_n low at the 3rd bit -> all outputs 0 asynchronously, no done; a later start restarts from SEED.
REQ-037 SHALL cover: MODE=1, SEED=0, LEN=3 -> loads 8'h01 and emits a = 1,0,0 (pattern 01,B8,5C).
